// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS pipeline: opcodes, ALU operation codes,
// control-bundle bit positions and the canonical nop word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALU_RTYPE tells EX to decode the funct field itself
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_RTYPE = 4'd2,
    ALU_AND   = 4'd3,
    ALU_OR    = 4'd4,
    ALU_LUI   = 4'd5
  } alu_op_t;

  // Bit positions inside the 10-bit ID/EX control bundle
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_TO_REG = 8;
  localparam int CTRL_MEM_READ   = 7;
  localparam int CTRL_MEM_WRITE  = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 4;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/id_stage_register_file.sv
// 32x32 register file: two combinational read ports with write-through
// bypass from the single write port; $0 is hard-wired to zero.
module register_file
  import mips_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h1001_03FC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_en,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  logic [31:0] regs [32];

  // Storage: reset clears everything except the stack pointer, writes to $0 are dropped
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= (i == 29) ? SP_INIT : 32'h0;
      end
    end else if (write_en && write_reg != 5'd0) begin
      regs[write_reg] <= write_data;
    end
  end

  // Read ports: $0 forced to zero, same-cycle write data bypassed to the reader
  always_comb begin
    read_data1 = regs[read_reg1];
    read_data2 = regs[read_reg2];
    if (write_en && write_reg != 5'd0 && write_reg == read_reg1) read_data1 = write_data;
    if (write_en && write_reg != 5'd0 && write_reg == read_reg2) read_data2 = write_data;
    if (read_reg1 == 5'd0) read_data1 = 32'h0;
    if (read_reg2 == 5'd0) read_data2 = 32'h0;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction Decode stage: IF/ID register, register file, main decoder,
// hazard detection, branch/jump resolution and the registered ID/EX bundle.
module id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h1001_03FC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_plus_4_in,
  input  logic        wb_reg_write_in,
  input  logic [4:0]  wb_write_reg_in,
  input  logic [31:0] wb_write_data_in,
  input  logic        ex_mem_read_in,
  input  logic        ex_reg_write_in,
  input  logic [4:0]  ex_write_reg_in,
  input  logic        mem_mem_read_in,
  input  logic [4:0]  mem_write_reg_in,
  output logic        stall_out,
  output logic        pc_src_out,
  output logic [31:0] pc_branch_out,
  output logic [9:0]  id_ex_ctrl_out,
  output logic [31:0] id_ex_rd1_out,
  output logic [31:0] id_ex_rd2_out,
  output logic [31:0] id_ex_imm_out,
  output logic [4:0]  id_ex_rs_out,
  output logic [4:0]  id_ex_rt_out,
  output logic [4:0]  id_ex_rd_out,
  output logic [31:0] id_ex_pc_plus_4_out
);

  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [9:0]  ctrl;
  logic [31:0] imm_ext;
  logic        uses_rs;
  logic        uses_rt;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        ex_hit;
  logic        mem_hit;
  logic        take;
  logic [31:0] branch_offset;

  assign opcode = if_id_instr[31:26];
  assign rs     = if_id_instr[25:21];
  assign rt     = if_id_instr[20:16];
  assign rd     = if_id_instr[15:11];
  assign imm16  = if_id_instr[15:0];

  register_file #(.SP_INIT(SP_INIT)) u_register_file (
    .clk        (clk),
    .reset      (reset),
    .write_en   (wb_reg_write_in),
    .write_reg  (wb_write_reg_in),
    .write_data (wb_write_data_in),
    .read_reg1  (rs),
    .read_reg2  (rt),
    .read_data1 (rd1),
    .read_data2 (rd2)
  );

  // Main decoder: control bundle, immediate form and which source registers are really read
  always_comb begin
    ctrl    = '0;
    imm_ext = {{16{imm16[15]}}, imm16};
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (if_id_instr != NOP_WORD) begin
          ctrl[CTRL_REG_WRITE] = 1'b1;
          ctrl[CTRL_REG_DST]   = 1'b1;
          ctrl[3:0]            = ALU_RTYPE;
          uses_rs              = 1'b1;
          uses_rt              = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[3:0]            = ALU_ADD;
        uses_rs              = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[3:0]            = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        imm_ext              = {16'h0, imm16};
        uses_rs              = 1'b1;
      end
      OP_LUI: begin
        ctrl[CTRL_REG_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[3:0]            = ALU_LUI;
        imm_ext              = {imm16, 16'h0};
      end
      OP_LW: begin
        ctrl[CTRL_REG_WRITE]  = 1'b1;
        ctrl[CTRL_MEM_TO_REG] = 1'b1;
        ctrl[CTRL_MEM_READ]   = 1'b1;
        ctrl[CTRL_ALU_SRC]    = 1'b1;
        ctrl[3:0]             = ALU_ADD;
        uses_rs               = 1'b1;
      end
      OP_SW: begin
        ctrl[CTRL_MEM_WRITE] = 1'b1;
        ctrl[CTRL_ALU_SRC]   = 1'b1;
        ctrl[3:0]            = ALU_ADD;
        uses_rs              = 1'b1;
        uses_rt              = 1'b1;
      end
      OP_BEQ: begin
        is_beq  = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_BNE: begin
        is_bne  = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_J: begin
        is_j = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign ex_hit  = (ex_write_reg_in != 5'd0) &&
                   ((uses_rs && ex_write_reg_in == rs) || (uses_rt && ex_write_reg_in == rt));
  assign mem_hit = (mem_write_reg_in != 5'd0) &&
                   ((uses_rs && mem_write_reg_in == rs) || (uses_rt && mem_write_reg_in == rt));

  // Branches compare in ID, so they must also wait for ALU results and loads still in flight
  assign stall_out = (ex_mem_read_in && ex_hit) ||
                     ((is_beq || is_bne) && ex_reg_write_in && ex_hit) ||
                     ((is_beq || is_bne) && mem_mem_read_in && mem_hit);

  assign take = !stall_out &&
                ((is_beq && rd1 == rd2) || (is_bne && rd1 != rd2) || is_j);

  assign branch_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign pc_src_out    = take;
  assign pc_branch_out = is_j ? {if_id_pc[31:28], if_id_instr[25:0], 2'b00}
                              : if_id_pc + branch_offset;

  // IF/ID register: hold on stall, squash the wrong-path slot after a taken branch/jump
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_id_instr <= NOP_WORD;
      if_id_pc    <= 32'h0;
    end else if (stall_out) begin
      if_id_instr <= if_id_instr;
      if_id_pc    <= if_id_pc;
    end else if (take) begin
      if_id_instr <= NOP_WORD;
      if_id_pc    <= 32'h0;
    end else begin
      if_id_instr <= instruction_in;
      if_id_pc    <= pc_plus_4_in;
    end
  end

  // ID/EX register: a stall injects an all-zero bubble, otherwise the decoded bundle moves on
  always_ff @(posedge clk) begin
    if (!reset || stall_out) begin
      id_ex_ctrl_out      <= '0;
      id_ex_rd1_out       <= '0;
      id_ex_rd2_out       <= '0;
      id_ex_imm_out       <= '0;
      id_ex_rs_out        <= '0;
      id_ex_rt_out        <= '0;
      id_ex_rd_out        <= '0;
      id_ex_pc_plus_4_out <= '0;
    end else begin
      id_ex_ctrl_out      <= ctrl;
      id_ex_rd1_out       <= rd1;
      id_ex_rd2_out       <= rd2;
      id_ex_imm_out       <= imm_ext;
      id_ex_rs_out        <= rs;
      id_ex_rt_out        <= rt;
      id_ex_rd_out        <= rd;
      id_ex_pc_plus_4_out <= if_id_pc;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ID/EX bundles are queued as stimulus
// is driven and popped one clock later; combinational outputs are checked inline.
module tb_id_stage;
  import mips_pkg::*;

  localparam logic [31:0] SP_INIT = 32'h1001_03FC;
  localparam logic [31:0] BEEF    = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] pc;
  } bundle_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction_in;
  logic [31:0] pc_plus_4_in;
  logic        wb_reg_write_in;
  logic [4:0]  wb_write_reg_in;
  logic [31:0] wb_write_data_in;
  logic        ex_mem_read_in;
  logic        ex_reg_write_in;
  logic [4:0]  ex_write_reg_in;
  logic        mem_mem_read_in;
  logic [4:0]  mem_write_reg_in;
  logic        stall_out;
  logic        pc_src_out;
  logic [31:0] pc_branch_out;
  logic [9:0]  id_ex_ctrl_out;
  logic [31:0] id_ex_rd1_out;
  logic [31:0] id_ex_rd2_out;
  logic [31:0] id_ex_imm_out;
  logic [4:0]  id_ex_rs_out;
  logic [4:0]  id_ex_rt_out;
  logic [4:0]  id_ex_rd_out;
  logic [31:0] id_ex_pc_plus_4_out;

  bundle_t exp_q [$];
  string   tag_q [$];
  int      n_compared = 0;
  int      n_mismatched = 0;

  id_stage #(.SP_INIT(SP_INIT)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instruction_in      (instruction_in),
    .pc_plus_4_in        (pc_plus_4_in),
    .wb_reg_write_in     (wb_reg_write_in),
    .wb_write_reg_in     (wb_write_reg_in),
    .wb_write_data_in    (wb_write_data_in),
    .ex_mem_read_in      (ex_mem_read_in),
    .ex_reg_write_in     (ex_reg_write_in),
    .ex_write_reg_in     (ex_write_reg_in),
    .mem_mem_read_in     (mem_mem_read_in),
    .mem_write_reg_in    (mem_write_reg_in),
    .stall_out           (stall_out),
    .pc_src_out          (pc_src_out),
    .pc_branch_out       (pc_branch_out),
    .id_ex_ctrl_out      (id_ex_ctrl_out),
    .id_ex_rd1_out       (id_ex_rd1_out),
    .id_ex_rd2_out       (id_ex_rd2_out),
    .id_ex_imm_out       (id_ex_imm_out),
    .id_ex_rs_out        (id_ex_rs_out),
    .id_ex_rt_out        (id_ex_rt_out),
    .id_ex_rd_out        (id_ex_rd_out),
    .id_ex_pc_plus_4_out (id_ex_pc_plus_4_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] enc_r(logic [4:0] s, logic [4:0] t, logic [4:0] d);
    return {OP_RTYPE, s, t, d, 5'd0, FUNCT_ADD};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [9:0] cf(logic rw, logic m2r, logic mr, logic mw, logic as, logic rdst,
                                    logic [3:0] op);
    return {rw, m2r, mr, mw, as, rdst, op};
  endfunction

  function automatic bundle_t mk(logic [9:0] c, logic [31:0] w, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] imm, logic [31:0] pc);
    bundle_t r;
    r.ctrl = c;
    r.rd1  = a;
    r.rd2  = b;
    r.imm  = imm;
    r.rs   = w[25:21];
    r.rt   = w[20:16];
    r.rd   = w[15:11];
    r.pc   = pc;
    return r;
  endfunction

  task automatic push(bundle_t b, string tag);
    exp_q.push_back(b);
    tag_q.push_back(tag);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic scoreboard_loop();
    bundle_t exp_b;
    bundle_t act;
    string   tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_b = exp_q.pop_front();
        tag   = tag_q.pop_front();
        act   = {id_ex_ctrl_out, id_ex_rd1_out, id_ex_rd2_out, id_ex_imm_out,
                 id_ex_rs_out, id_ex_rt_out, id_ex_rd_out, id_ex_pc_plus_4_out};
        n_compared++;
        if (act !== exp_b) begin
          n_mismatched++;
          $display("[TB] FAIL %s: id_ex got %h required %h", tag, act, exp_b);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] w;
    reset = 1'b0;
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    wb_reg_write_in = 1'b0; wb_write_reg_in = 5'd0; wb_write_data_in = 32'h0;
    ex_mem_read_in = 1'b0; ex_reg_write_in = 1'b0; ex_write_reg_in = 5'd0;
    mem_mem_read_in = 1'b0; mem_write_reg_in = 5'd0;
    push('0, "reset_cycle1");
    step();
    push('0, "reset_cycle2");
    step();
    n_compared++;
    if (stall_out !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_stall: got %b required 0", stall_out);
    end
    n_compared++;
    if (pc_src_out !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL reset_pc_src: got %b required 0", pc_src_out);
    end
    reset = 1'b1;
    w = enc_r(5'd29, 5'd5, 5'd10);
    instruction_in = w; pc_plus_4_in = 32'h4;
    push('0, "nop_after_reset");
    step();
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    push(mk(cf(1, 0, 0, 0, 0, 1, ALU_RTYPE), w, SP_INIT, 32'h0, 32'h0000_5020, 32'h4), "read_sp_and_r5");
    step();
  endtask

  task automatic test_writeback_bypass();
    logic [31:0] w;
    w = enc_r(5'd8, 5'd0, 5'd9);
    instruction_in = w; pc_plus_4_in = 32'h8;
    step();
    instruction_in = 32'h0;
    wb_reg_write_in = 1'b1; wb_write_reg_in = 5'd8; wb_write_data_in = BEEF;
    push(mk(cf(1, 0, 0, 0, 0, 1, ALU_RTYPE), w, BEEF, 32'h0, 32'h0000_4820, 32'h8), "wb_bypass_r8");
    step();
    w = enc_r(5'd0, 5'd8, 5'd11);
    instruction_in = w; pc_plus_4_in = 32'hC;
    wb_write_reg_in = 5'd0; wb_write_data_in = 32'h1234_5678;
    step();
    instruction_in = 32'h0;
    push(mk(cf(1, 0, 0, 0, 0, 1, ALU_RTYPE), w, 32'h0, BEEF, 32'h0000_5820, 32'hC), "write_r0_ignored");
    step();
    wb_reg_write_in = 1'b0; wb_write_data_in = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [8];
    bundle_t     exps  [8];
    words[0] = enc_i(OP_ADDI, 5'd8, 5'd2, 16'hFFFC);
    exps[0]  = mk(cf(1, 0, 0, 0, 1, 0, ALU_ADD), words[0], BEEF, 32'h0, 32'hFFFF_FFFC, 32'h100);
    words[1] = enc_i(OP_ANDI, 5'd29, 5'd3, 16'hF0F0);
    exps[1]  = mk(cf(1, 0, 0, 0, 1, 0, ALU_AND), words[1], SP_INIT, 32'h0, 32'h0000_F0F0, 32'h104);
    words[2] = enc_i(OP_ORI, 5'd8, 5'd4, 16'h8001);
    exps[2]  = mk(cf(1, 0, 0, 0, 1, 0, ALU_OR), words[2], BEEF, 32'h0, 32'h0000_8001, 32'h108);
    words[3] = enc_i(OP_LUI, 5'd0, 5'd5, 16'h1234);
    exps[3]  = mk(cf(1, 0, 0, 0, 1, 0, ALU_LUI), words[3], 32'h0, 32'h0, 32'h1234_0000, 32'h10C);
    words[4] = enc_i(OP_LW, 5'd29, 5'd6, 16'h0008);
    exps[4]  = mk(cf(1, 1, 1, 0, 1, 0, ALU_ADD), words[4], SP_INIT, 32'h0, 32'h0000_0008, 32'h110);
    words[5] = enc_i(OP_SW, 5'd29, 5'd8, 16'hFFF8);
    exps[5]  = mk(cf(0, 0, 0, 1, 1, 0, ALU_ADD), words[5], SP_INIT, BEEF, 32'hFFFF_FFF8, 32'h114);
    words[6] = enc_i(6'b111111, 5'd8, 5'd8, 16'h0001);
    exps[6]  = mk(10'h000, words[6], BEEF, BEEF, 32'h0000_0001, 32'h118);
    words[7] = enc_r(5'd8, 5'd29, 5'd12);
    exps[7]  = mk(cf(1, 0, 0, 0, 0, 1, ALU_RTYPE), words[7], BEEF, SP_INIT, 32'h0000_6020, 32'h11C);
    for (int i = 0; i < 8; i++) begin
      instruction_in = words[i];
      pc_plus_4_in   = 32'h100 + 32'(4 * i);
      step();
      push(exps[i], $sformatf("b2b_%0d", i));
    end
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    step();
  endtask

  task automatic test_load_use();
    logic [31:0] w;
    logic [31:0] w2;
    w  = enc_r(5'd2, 5'd1, 5'd3);
    w2 = enc_i(OP_ORI, 5'd0, 5'd7, 16'h00FF);
    instruction_in = w; pc_plus_4_in = 32'h40;
    step();
    instruction_in = w2; pc_plus_4_in = 32'h44;
    ex_mem_read_in = 1'b1; ex_write_reg_in = 5'd2;
    #1;
    n_compared++;
    if (stall_out !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL load_use_stall: got %b required 1", stall_out);
    end
    push('0, "load_use_bubble");
    step();
    ex_mem_read_in = 1'b0; ex_write_reg_in = 5'd0;
    #1;
    n_compared++;
    if (stall_out !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL load_use_release: got %b required 0", stall_out);
    end
    push(mk(cf(1, 0, 0, 0, 0, 1, ALU_RTYPE), w, 32'h0, 32'h0, 32'h0000_1820, 32'h40), "load_use_held_add");
    step();
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    push(mk(cf(1, 0, 0, 0, 1, 0, ALU_OR), w2, 32'h0, 32'h0, 32'h0000_00FF, 32'h44), "load_use_next_ori");
    step();
  endtask

  task automatic test_branch();
    logic [31:0] w;
    w = enc_i(OP_BEQ, 5'd1, 5'd1, 16'h0003);
    instruction_in = w; pc_plus_4_in = 32'h10;
    step();
    instruction_in = enc_i(OP_ADDI, 5'd0, 5'd1, 16'h0007); pc_plus_4_in = 32'h14;
    #1;
    n_compared++;
    if (pc_src_out !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL beq_taken: got %b required 1", pc_src_out);
    end
    n_compared++;
    if (pc_branch_out !== 32'h0000_001C) begin
      n_mismatched++; $display("[TB] FAIL beq_target: got %h required 0000001c", pc_branch_out);
    end
    push(mk(10'h000, w, 32'h0, 32'h0, 32'h0000_0003, 32'h10), "beq_in_id_ex");
    step();
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    push('0, "beq_flush_nop");
    step();
    w = enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFE);
    instruction_in = w; pc_plus_4_in = 32'h4;
    step();
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    #1;
    n_compared++;
    if (pc_branch_out !== 32'hFFFF_FFFC) begin
      n_mismatched++; $display("[TB] FAIL beq_wrap_target: got %h required fffffffc", pc_branch_out);
    end
    push(mk(10'h000, w, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h4), "beq_wrap_in_id_ex");
    step();
    push('0, "beq_wrap_flush");
    step();
  endtask

  task automatic test_bne_jump();
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    w1 = enc_i(OP_BNE, 5'd8, 5'd8, 16'h0005);
    w2 = {OP_J, 26'h000_0040};
    w3 = enc_i(OP_BNE, 5'd8, 5'd0, 16'h0002);
    instruction_in = w1; pc_plus_4_in = 32'h50;
    step();
    instruction_in = w2; pc_plus_4_in = 32'h20;
    #1;
    n_compared++;
    if (pc_src_out !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL bne_equal_not_taken: got %b required 0", pc_src_out);
    end
    push(mk(10'h000, w1, BEEF, BEEF, 32'h0000_0005, 32'h50), "bne_in_id_ex");
    step();
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    #1;
    n_compared++;
    if (pc_src_out !== 1'b1 || pc_branch_out !== 32'h0000_0100) begin
      n_mismatched++;
      $display("[TB] FAIL jump_target: got src=%b tgt=%h required src=1 tgt=00000100", pc_src_out, pc_branch_out);
    end
    push(mk(10'h000, w2, 32'h0, 32'h0, 32'h0000_0040, 32'h20), "j_in_id_ex");
    step();
    push('0, "j_flush_nop");
    step();
    instruction_in = w3; pc_plus_4_in = 32'h30;
    step();
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    #1;
    n_compared++;
    if (pc_src_out !== 1'b1 || pc_branch_out !== 32'h0000_0038) begin
      n_mismatched++;
      $display("[TB] FAIL bne_taken: got src=%b tgt=%h required src=1 tgt=00000038", pc_src_out, pc_branch_out);
    end
    push(mk(10'h000, w3, BEEF, 32'h0, 32'h0000_0002, 32'h30), "bne_taken_in_id_ex");
    step();
    push('0, "bne_taken_flush");
    step();
  endtask

  task automatic test_branch_hazard();
    logic [31:0] w;
    logic [31:0] w2;
    w  = enc_i(OP_BEQ, 5'd4, 5'd5, 16'h0001);
    w2 = enc_r(5'd8, 5'd29, 5'd9);
    instruction_in = w; pc_plus_4_in = 32'h60;
    step();
    instruction_in = w2; pc_plus_4_in = 32'h64;
    mem_mem_read_in = 1'b1; mem_write_reg_in = 5'd5;
    #1;
    n_compared++;
    if (stall_out !== 1'b1 || pc_src_out !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL mem_load_branch: got stall=%b src=%b required stall=1 src=0", stall_out, pc_src_out);
    end
    mem_mem_read_in = 1'b0; mem_write_reg_in = 5'd0;
    ex_reg_write_in = 1'b1; ex_write_reg_in = 5'd4;
    #1;
    n_compared++;
    if (stall_out !== 1'b1 || pc_src_out !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL ex_alu_branch: got stall=%b src=%b required stall=1 src=0", stall_out, pc_src_out);
    end
    push('0, "branch_hazard_bubble");
    step();
    n_compared++;
    if (stall_out !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL branch_still_held: got %b required 1", stall_out);
    end
    reset = 1'b0;
    push('0, "mid_stall_reset");
    step();
    reset = 1'b1;
    ex_reg_write_in = 1'b0; ex_write_reg_in = 5'd0;
    instruction_in = w2; pc_plus_4_in = 32'h70;
    #1;
    n_compared++;
    if (stall_out !== 1'b0 || pc_src_out !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_clean: got stall=%b src=%b required 0 0", stall_out, pc_src_out);
    end
    push('0, "post_reset_nop");
    step();
    instruction_in = 32'h0; pc_plus_4_in = 32'h0;
    push(mk(cf(1, 0, 0, 0, 0, 1, ALU_RTYPE), w2, 32'h0, SP_INIT, 32'h0000_4820, 32'h70), "regfile_reset");
    step();
  endtask

  initial begin
    $display("[TB] id_stage scoreboard bench start");
    fork
      scoreboard_loop();
    join_none
    test_reset();
    test_writeback_bypass();
    test_back_to_back();
    test_load_use();
    test_branch();
    test_bne_jump();
    test_branch_hazard();
    step();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
